// File: rtl/interrupt_sequencer_pkg.sv
// rtl/interrupt_sequencer_pkg.sv - shared state type and default constants for interrupt_sequencer
package interrupt_sequencer_pkg;

  localparam int          ISQ_PC_W         = 32;
  localparam int          ISQ_FLAG_W       = 3;
  localparam int          ISQ_DRAIN_CYCLES = 3;
  localparam logic [15:0] ISQ_VECTOR_ADDR  = 16'h0000;

  typedef enum logic [3:0] {
    IDLE,
    DRAIN,
    PUSH_HI,
    PUSH_LO,
    PUSH_FLG,
    VEC_LO,
    VEC_HI,
    JUMP,
    RTI_DRAIN,
    POP_FLG,
    POP_LO,
    POP_HI,
    RET
  } isq_state_t;

endpackage

// File: rtl/interrupt_sequencer_irq_edge_sync.sv
// rtl/interrupt_sequencer_irq_edge_sync.sv - two-flop irq synchroniser with rising-edge detect
module interrupt_sequencer_irq_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  output logic irq_rise
);

  logic sync_1;
  logic sync_2;
  logic sync_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_1    <= irq;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
    end
  end

  assign irq_rise = sync_2 & ~sync_prev;

endmodule

// File: rtl/interrupt_sequencer.sv
// rtl/interrupt_sequencer.sv - sequences pipeline drain, context push/pop and vector fetch for irq entry and RTI
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
#(
  parameter logic [15:0] VECTOR_ADDR  = ISQ_VECTOR_ADDR,
  parameter int          DRAIN_CYCLES = ISQ_DRAIN_CYCLES,
  parameter int          PC_W         = ISQ_PC_W,
  parameter int          FLAG_W       = ISQ_FLAG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              irq,
  input  logic              rti_dec,
  input  logic              pipe_busy,
  input  logic [PC_W-1:0]   pc_resume,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic [15:0]       mem_rdata,
  output logic              stall_fetch,
  output logic              flush_pipe,
  output logic              mem_push,
  output logic              mem_pop,
  output logic              mem_read,
  output logic [15:0]       mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              pc_write,
  output logic [PC_W-1:0]   pc_value,
  output logic              flags_we,
  output logic [FLAG_W-1:0] flags_out,
  output logic              int_ack,
  output logic              busy
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  isq_state_t        state;
  isq_state_t        state_n;
  logic [CNT_W-1:0]  drain_cnt;
  logic              drain_done;
  logic [PC_W-1:0]   pc_hold;
  logic [FLAG_W-1:0] flags_hold;
  logic [15:0]       vec_lo;
  logic [15:0]       pc_lo;
  logic              pending;
  logic              requeue;
  logic              irq_rise;
  logic              in_entry;

  interrupt_sequencer_irq_edge_sync u_irq_sync (
    .clk      (clk),
    .rst      (rst),
    .irq      (irq),
    .irq_rise (irq_rise)
  );

  assign drain_done = (drain_cnt == CNT_W'(DRAIN_CYCLES - 1));
  assign in_entry   = (state == DRAIN)    || (state == PUSH_HI) || (state == PUSH_LO) ||
                      (state == PUSH_FLG) || (state == VEC_LO)  || (state == VEC_HI);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      drain_cnt  <= '0;
      pc_hold    <= '0;
      flags_hold <= '0;
      vec_lo     <= '0;
      pc_lo      <= '0;
      pending    <= 1'b0;
      requeue    <= 1'b0;
    end else begin
      state <= state_n;

      if ((state == DRAIN) || (state == RTI_DRAIN)) drain_cnt <= drain_cnt + 1'b1;
      else                                          drain_cnt <= '0;

      if ((state == IDLE) && (state_n == DRAIN)) begin
        pc_hold    <= pc_resume;
        flags_hold <= flags_in;
      end
      if (state == VEC_HI) vec_lo <= mem_rdata;
      if (state == POP_HI) pc_lo  <= mem_rdata;

      // An edge arriving while the current request is in flight must survive
      // the pending clear that happens on the way into JUMP.
      if (state == VEC_HI) begin
        pending <= requeue | irq_rise;
        requeue <= 1'b0;
      end else if (in_entry) begin
        requeue <= requeue | irq_rise;
      end else begin
        pending <= pending | irq_rise;
      end
    end
  end

  always_comb begin
    state_n     = state;
    stall_fetch = 1'b0;
    flush_pipe  = 1'b0;
    mem_push    = 1'b0;
    mem_pop     = 1'b0;
    mem_read    = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    pc_write    = 1'b0;
    pc_value    = '0;
    flags_we    = 1'b0;
    flags_out   = '0;
    int_ack     = 1'b0;
    busy        = (state != IDLE);

    case (state)
      IDLE: begin
        if (rti_dec)                     state_n = RTI_DRAIN;
        else if (pending && !pipe_busy)  state_n = DRAIN;
      end
      DRAIN: begin
        stall_fetch = 1'b1;
        flush_pipe  = 1'b1;
        if (drain_done) state_n = PUSH_HI;
      end
      PUSH_HI: begin
        stall_fetch = 1'b1;
        mem_push    = 1'b1;
        mem_wdata   = pc_hold[PC_W-1 -: 16];
        state_n     = PUSH_LO;
      end
      PUSH_LO: begin
        stall_fetch = 1'b1;
        mem_push    = 1'b1;
        mem_wdata   = pc_hold[15:0];
        state_n     = PUSH_FLG;
      end
      PUSH_FLG: begin
        stall_fetch = 1'b1;
        mem_push    = 1'b1;
        mem_wdata   = 16'(flags_hold);
        state_n     = VEC_LO;
      end
      VEC_LO: begin
        stall_fetch = 1'b1;
        mem_read    = 1'b1;
        mem_addr    = VECTOR_ADDR;
        state_n     = VEC_HI;
      end
      VEC_HI: begin
        stall_fetch = 1'b1;
        mem_read    = 1'b1;
        mem_addr    = VECTOR_ADDR + 16'd1;
        state_n     = JUMP;
      end
      JUMP: begin
        stall_fetch = 1'b1;
        flush_pipe  = 1'b1;
        pc_write    = 1'b1;
        pc_value    = PC_W'({mem_rdata, vec_lo});
        int_ack     = 1'b1;
        state_n     = IDLE;
      end
      RTI_DRAIN: begin
        stall_fetch = 1'b1;
        flush_pipe  = 1'b1;
        if (drain_done) state_n = POP_FLG;
      end
      POP_FLG: begin
        stall_fetch = 1'b1;
        mem_pop     = 1'b1;
        state_n     = POP_LO;
      end
      POP_LO: begin
        stall_fetch = 1'b1;
        mem_pop     = 1'b1;
        flags_we    = 1'b1;
        flags_out   = mem_rdata[FLAG_W-1:0];
        state_n     = POP_HI;
      end
      POP_HI: begin
        stall_fetch = 1'b1;
        mem_pop     = 1'b1;
        state_n     = RET;
      end
      RET: begin
        stall_fetch = 1'b1;
        flush_pipe  = 1'b1;
        pc_write    = 1'b1;
        pc_value    = PC_W'({mem_rdata, pc_lo});
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb/tb_interrupt_sequencer.sv - scoreboard bench for interrupt_sequencer entry/RTI sequencing
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        rst, irq, rti_dec, pipe_busy;
  logic [31:0] pc_resume;
  logic [2:0]  flags_in;
  logic [15:0] mem_rdata;
  logic        stall_fetch, flush_pipe, mem_push, mem_pop, mem_read;
  logic [15:0] mem_addr, mem_wdata;
  logic        pc_write, flags_we, int_ack, busy;
  logic [31:0] pc_value;
  logic [2:0]  flags_out;

  interrupt_sequencer dut (
    .clk(clk), .rst(rst), .irq(irq), .rti_dec(rti_dec), .pipe_busy(pipe_busy),
    .pc_resume(pc_resume), .flags_in(flags_in), .mem_rdata(mem_rdata),
    .stall_fetch(stall_fetch), .flush_pipe(flush_pipe), .mem_push(mem_push),
    .mem_pop(mem_pop), .mem_read(mem_read), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .pc_write(pc_write), .pc_value(pc_value), .flags_we(flags_we), .flags_out(flags_out),
    .int_ack(int_ack), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  // strb = {push, pop, read, pc_write, flags_we, int_ack}; sf = {stall, flush}
  typedef struct packed {
    logic [5:0]  strb;
    logic [1:0]  sf;
    logic [15:0] wdata;
    logic [15:0] addr;
    logic [31:0] pcv;
    logic [2:0]  flg;
    logic [7:0]  off;
  } ev_t;

  ev_t         exp_q[$];
  logic [15:0] stk[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          entry_cyc = 0;
  logic        prev_busy = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic ev_t mk(input logic [5:0] strb, input logic [1:0] sf, input logic [15:0] w,
                             input logic [15:0] a, input logic [31:0] p, input logic [2:0] f,
                             input logic [7:0] off);
    ev_t e;
    e.strb = strb; e.sf = sf; e.wdata = w; e.addr = a; e.pcv = p; e.flg = f; e.off = off;
    return e;
  endfunction

  // Offsets count cycles from the first busy cycle; vector is {mem[1], mem[0]} = 32'h0000_0100.
  task automatic exp_entry(input logic [31:0] pc, input logic [2:0] fl, input bit full);
    exp_q.push_back(mk(6'b100000, 2'b10, pc[31:16],       16'h0, 32'h0, 3'b0, 8'd3));
    exp_q.push_back(mk(6'b100000, 2'b10, pc[15:0],        16'h0, 32'h0, 3'b0, 8'd4));
    exp_q.push_back(mk(6'b100000, 2'b10, {13'b0, fl},     16'h0, 32'h0, 3'b0, 8'd5));
    exp_q.push_back(mk(6'b001000, 2'b10, 16'h0,           16'h0, 32'h0, 3'b0, 8'd6));
    exp_q.push_back(mk(6'b001000, 2'b10, 16'h0,           16'h1, 32'h0, 3'b0, 8'd7));
    if (full)
      exp_q.push_back(mk(6'b000101, 2'b11, 16'h0, 16'h0, 32'h0000_0100, 3'b0, 8'd8));
  endtask

  task automatic exp_rti(input logic [31:0] pc, input logic [2:0] fl);
    exp_q.push_back(mk(6'b010000, 2'b10, 16'h0, 16'h0, 32'h0, 3'b0, 8'd3));
    exp_q.push_back(mk(6'b010010, 2'b10, 16'h0, 16'h0, 32'h0, fl,   8'd4));
    exp_q.push_back(mk(6'b010000, 2'b10, 16'h0, 16'h0, 32'h0, 3'b0, 8'd5));
    exp_q.push_back(mk(6'b000100, 2'b11, 16'h0, 16'h0, pc,   3'b0, 8'd6));
  endtask

  // Data memory + stack model: response appears one cycle after the strobe.
  initial begin : mem_model
    logic p, o, r;
    logic [15:0] a, w;
    mem_rdata = 16'h0;
    forever begin
      @(negedge clk);
      p = mem_push; o = mem_pop; r = mem_read; a = mem_addr; w = mem_wdata;
      @(posedge clk);
      #1;
      if (p) stk.push_back(w);
      if (o) begin
        if (stk.size() > 0) mem_rdata = stk.pop_back();
        else                mem_rdata = 16'hDEAD;
      end
      if (r) mem_rdata = (a == 16'h0000) ? 16'h0100 : (a == 16'h0001) ? 16'h0000 : 16'hDEAD;
    end
  end

  initial begin : monitor
    ev_t act, e;
    forever begin
      @(negedge clk);
      if (busy && !prev_busy) entry_cyc = cyc;
      prev_busy = busy;
      act.strb  = {mem_push, mem_pop, mem_read, pc_write, flags_we, int_ack};
      act.sf    = {stall_fetch, flush_pipe};
      act.wdata = mem_push ? mem_wdata : 16'h0;
      act.addr  = mem_read ? mem_addr : 16'h0;
      act.pcv   = pc_write ? pc_value : 32'h0;
      act.flg   = flags_we ? flags_out : 3'b0;
      act.off   = 8'(cyc - entry_cyc);
      if (act.strb != 6'b0) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_strobe: got %h expected none", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            n_fail++;
            $display("FAIL scoreboard_event: got %h expected %h", act, e);
          end
        end
      end else if (busy) begin
        check("drain_stall_flush", {61'b0, stall_fetch, flush_pipe, ((cyc - entry_cyc) < 3)}, 64'b111);
      end
    end
  end

  task automatic check_all_zero(input string name);
    check({name, "_ctl"}, {55'b0, stall_fetch, flush_pipe, mem_push, mem_pop, mem_read,
                           pc_write, flags_we, int_ack, busy}, 64'h0);
    check({name, "_data"}, {29'b0, mem_addr, mem_wdata, flags_out}, 64'h0);
    check({name, "_pc"}, {32'b0, pc_value}, 64'h0);
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    while (!busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(name, {63'b0, busy}, 64'h1);
  endtask

  task automatic settle(input string name);
    repeat (25) @(negedge clk);
    check({name, "_idle"}, {63'b0, busy}, 64'h0);
    check({name, "_queue_empty"}, 64'(exp_q.size()), 64'h0);
  endtask

  task automatic quiet(input string name);
    logic seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | busy;
    end
    check(name, {63'b0, seen}, 64'h0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stimulus
    rst = 1'b0; irq = 1'b0; rti_dec = 1'b0; pipe_busy = 1'b0;
    pc_resume = 32'h0; flags_in = 3'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1: interrupt entry
    pc_resume = 32'h0001_0020; flags_in = 3'b101;
    exp_entry(32'h0001_0020, 3'b101, 1'b1);
    irq = 1'b1;
    wait_busy("t1_entry");
    @(negedge clk);
    irq = 1'b0;
    settle("t1");

    // 2: RTI restores the frame pushed by case 1
    exp_rti(32'h0001_0020, 3'b101);
    rti_dec = 1'b1;
    @(negedge clk);
    rti_dec = 1'b0;
    wait_busy("t2_entry");
    settle("t2");

    // 3: pipe_busy defers entry
    pc_resume = 32'h1234_5678; flags_in = 3'b010;
    pipe_busy = 1'b1;
    irq = 1'b1;
    exp_entry(32'h1234_5678, 3'b010, 1'b1);
    begin
      logic seen = 1'b0;
      repeat (8) begin
        @(negedge clk);
        seen = seen | busy;
      end
      check("t3_held_idle", {63'b0, seen}, 64'h0);
    end
    pipe_busy = 1'b0;
    @(negedge clk);
    check("t3_drain_on_release", {63'b0, busy}, 64'h1);
    irq = 1'b0;
    settle("t3");

    // 4: irq and rti_dec together: RTI first, then entry
    pc_resume = 32'hCAFE_0004; flags_in = 3'b111;
    exp_rti(32'h1234_5678, 3'b010);
    exp_entry(32'hCAFE_0004, 3'b111, 1'b1);
    rti_dec = 1'b1;
    irq = 1'b1;
    @(negedge clk);
    rti_dec = 1'b0;
    settle("t4");
    irq = 1'b0;
    repeat (3) @(negedge clk);

    // 5: two further edges during entry are serviced exactly once
    pc_resume = 32'h0000_0200; flags_in = 3'b001;
    exp_entry(32'h0000_0200, 3'b001, 1'b1);
    exp_entry(32'h0000_0200, 3'b001, 1'b1);
    irq = 1'b1;
    wait_busy("t5_entry");
    @(negedge clk);
    irq = 1'b0;
    repeat (3) @(negedge clk);
    irq = 1'b1;
    @(negedge clk);
    irq = 1'b0;
    @(negedge clk);
    irq = 1'b1;
    @(negedge clk);
    irq = 1'b0;
    settle("t5");
    quiet("t5_no_third_entry");

    // 6: reset during VEC_HI aborts cleanly
    pc_resume = 32'h0BAD_0010; flags_in = 3'b100;
    exp_entry(32'h0BAD_0010, 3'b100, 1'b0);
    irq = 1'b1;
    wait_busy("t6_entry");
    repeat (7) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("t6_reset");
    irq = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    quiet("t6_no_resume");
    check("t6_queue_empty", 64'(exp_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
